// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command queue: FSM states, command layout, default widths.
package apb_cmd_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Small synchronous FIFO holding packed commands; head is visible while not empty.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/apb_cmd_queue.sv
// Command sequencer in front of the APB master: queues client commands, issues one at a
// time, returns response/status. Optional WAIT timeout when APB_TIMEOUT_EN is defined.
module apb_cmd_queue
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              Transfer,
  output logic              Wr_Rd,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              xfer_done,
  input  logic              xfer_err
);

  localparam int CW = 1 + ADDR_W + DATA_W;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_head;

  // Both channels: a beat transfers on a rising edge where valid and ready are high;
  // the sender keeps valid and payload steady until then, ready may change freely.
  assign cmd_ready = !fifo_full;

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .push      (cmd_valid),
    .push_data ({cmd_write, cmd_addr, cmd_wdata}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  state_e            state_q, state_d;
  logic              transfer_q, transfer_d;
  logic              wr_rd_q, wr_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign rsp_timeout    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    transfer_d  = transfer_q;
    wr_rd_d     = wr_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          transfer_d = 1'b1;
          wr_rd_d    = fifo_head[CW-1];
          addr_d     = fifo_head[DATA_W +: ADDR_W];
          wdata_d    = fifo_head[DATA_W-1:0];
          state_d    = WAIT;
`ifdef APB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        // A completion on the expiry cycle still counts as a normal completion.
        if (xfer_done) begin
          transfer_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = wr_rd_q;
          rsp_rdata_d = wr_rd_q ? '0 : read_data;
          rsp_err_d   = xfer_err;
          state_d     = RESP;
`ifdef APB_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          transfer_d    = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = wr_rd_q;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      transfer_q  <= 1'b0;
      wr_rd_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      transfer_q  <= transfer_d;
      wr_rd_q     <= wr_rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign Transfer   = transfer_q;
  assign Wr_Rd      = wr_rd_q;
  assign Address    = addr_q;
  assign write_data = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule
